// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl
//
// Purpose:
//   Sequencing controller that sits between a narrow valid/ready stream and
//   the wide flattened ports of matrix_mult_parallel_flat. It collects two
//   n x n operands in row-major order, pulses the multiplier enable for two
//   cycles, captures the flattened product and streams it back out in
//   row-major order with a last marker.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start_i             begin a job (sampled only while idle)
//   matrix_size_i       n for the job, sampled with start_i
//   busy_o              high whenever a job is in progress
//   size_err_o          one-cycle pulse after start_i with n==0 or n>MAX_SIZE
//   in_valid_i/in_ready_o/in_data_i     operand stream (A first, then B)
//   out_valid_o/out_ready_i/out_data_o/out_last_o   result stream
//   mult_enable_o, mult_size_o, mult_A_o, mult_B_o  multiplier drive
//   mult_C_i, mult_done_i                           multiplier result
module matmul_stream_ctrl #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic [31:0]                            matrix_size_i,
    output logic                                   busy_o,
    output logic                                   size_err_o,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]                  in_data_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [DATA_WIDTH-1:0]                  out_data_o,
    output logic                                   out_last_o,
    output logic                                   mult_enable_o,
    output logic [31:0]                            mult_size_o,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] mult_A_o,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] mult_B_o,
    input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] mult_C_i,
    input  logic                                   mult_done_i
);

    localparam int FLAT_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
    // Wide enough for a flat element index; row/col share it for simple math.
    localparam int IDXW   = $clog2(MAX_SIZE * MAX_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMP1,
        COMP2,
        CAPTURE,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       size_q, size_d;
    logic [IDXW-1:0]   row_q, row_d;
    logic [IDXW-1:0]   col_q, col_d;
    logic [FLAT_W-1:0] a_q, a_d;
    logic [FLAT_W-1:0] b_q, b_d;
    logic [FLAT_W-1:0] c_q, c_d;
    logic              size_err_q, size_err_d;

    logic [IDXW-1:0]   elem_idx;
    logic              last_col;
    logic              last_row;
    logic              size_ok;

    // The multiplier's done flag is implied by the fixed COMP1/COMP2 timing.
    logic              unused_mult_done;
    assign unused_mult_done = mult_done_i;

    // Buffer layout always uses MAX_SIZE as the row stride, independent of n.
    assign elem_idx = row_q * IDXW'(MAX_SIZE) + col_q;
    assign last_col = (32'(col_q) == size_q - 32'd1);
    assign last_row = (32'(row_q) == size_q - 32'd1);
    assign size_ok  = (matrix_size_i != 32'd0) && (matrix_size_i <= 32'(MAX_SIZE));

    assign busy_o        = (state_q != IDLE);
    assign size_err_o    = size_err_q;
    assign in_ready_o    = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign mult_enable_o = (state_q == COMP1) || (state_q == COMP2);
    assign mult_size_o   = busy_o ? size_q : 32'd0;
    assign mult_A_o      = a_q;
    assign mult_B_o      = b_q;
    assign out_valid_o   = (state_q == DRAIN);
    assign out_data_o    = (state_q == DRAIN) ? c_q[elem_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_last_o    = (state_q == DRAIN) && last_row && last_col;

    // Next-state logic: one element moves per handshake in the load and
    // drain phases, with col wrapping into row at n-1.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        row_d      = row_q;
        col_d      = col_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        size_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (size_ok) begin
                        size_d  = matrix_size_i;
                        a_d     = '0;
                        b_d     = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        size_err_d = 1'b1;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (in_valid_i) begin
                    if (state_q == LOAD_A) begin
                        a_d[elem_idx*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                    end else begin
                        b_d[elem_idx*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                    end
                    if (last_row && last_col) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : COMP1;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            COMP1: state_d = COMP2;
            COMP2: state_d = CAPTURE;
            CAPTURE: begin
                c_d     = mult_C_i;
                row_d   = '0;
                col_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready_i) begin
                    if (last_row && last_col) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears every buffer so an aborted
    // job cannot leak operands or results into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            size_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            row_q      <= row_d;
            col_q      <= col_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            size_err_q <= size_err_d;
        end
    end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// tb_matmul_stream_ctrl
//
// Purpose:
//   Self-checking bench for matmul_stream_ctrl. A behavioural stand-in for
//   the parallel multiplier sits on the wide ports; expected results come
//   from a plain integer matrix product of the operands the bench streams in.
module tb_matmul_stream_ctrl;

    localparam int MAX = 10;
    localparam int DW  = 32;
    localparam int FW  = MAX * MAX * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [31:0]   matrix_size_i;
    logic          busy_o;
    logic          size_err_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          mult_enable_o;
    logic [31:0]   mult_size_o;
    logic [FW-1:0] mult_A_o;
    logic [FW-1:0] mult_B_o;
    logic [FW-1:0] mult_C;
    logic          mult_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] aMat [MAX*MAX];
    logic [31:0] bMat [MAX*MAX];

    matmul_stream_ctrl #(.MAX_SIZE(MAX), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .matrix_size_i(matrix_size_i),
        .busy_o       (busy_o),
        .size_err_o   (size_err_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .mult_enable_o(mult_enable_o),
        .mult_size_o  (mult_size_o),
        .mult_A_o     (mult_A_o),
        .mult_B_o     (mult_B_o),
        .mult_C_i     (mult_C),
        .mult_done_i  (mult_done)
    );

    always #5 clk = ~clk;

    // Stand-in for matrix_mult_parallel_flat: first enabled edge registers
    // the operands, second enabled edge produces the product.
    function automatic logic [FW-1:0] matmulFlat(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                                 input int n);
        logic [FW-1:0] r;
        logic [31:0]   s;
        r = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 32'd0;
                for (int k = 0; k < n; k++) begin
                    s = s + a[(i*MAX+k)*DW +: DW] * b[(k*MAX+j)*DW +: DW];
                end
                r[(i*MAX+j)*DW +: DW] = s;
            end
        end
        return r;
    endfunction

    logic          mulPhase;
    logic [FW-1:0] opA, opB;
    int            opN;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mulPhase  <= 1'b0;
            mult_done <= 1'b0;
            mult_C    <= '0;
            opA       <= '0;
            opB       <= '0;
            opN       <= 0;
        end else if (mult_enable_o) begin
            if (!mulPhase) begin
                opA       <= mult_A_o;
                opB       <= mult_B_o;
                opN       <= int'(mult_size_o);
                mult_done <= 1'b0;
                mulPhase  <= 1'b1;
            end else begin
                mult_C    <= matmulFlat(opA, opB, opN);
                mult_done <= 1'b1;
                mulPhase  <= 1'b0;
            end
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one complete job from start to the final result handshake.
    // readyMode: 0 = always ready, 1 = toggle every cycle, 2 = random.
    task automatic applyStimulus(input int n, input int inPct, input int readyMode);
        logic [31:0] expC [MAX*MAX];
        logic [31:0] s;
        logic [31:0] prevData;
        logic        prevLast;
        logic        stalled;
        int          feedIdx, outIdx, cyc, lastBCyc, firstValidCyc, enCnt;

        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 32'd0;
                for (int k = 0; k < n; k++) s = s + aMat[i*n+k] * bMat[k*n+j];
                expC[i*n+j] = s;
            end
        end

        @(negedge clk);
        start_i       = 1'b1;
        matrix_size_i = 32'(n);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checkOutput("busy_after_start", {63'd0, busy_o}, 64'd1);
        checkOutput("mult_size", {32'd0, mult_size_o}, 64'(n));

        feedIdx = 0; outIdx = 0; cyc = 0; lastBCyc = -100; firstValidCyc = -1;
        enCnt = 0; stalled = 1'b0; prevData = '0; prevLast = 1'b0;

        while (outIdx < n*n && cyc < 5000) begin
            in_valid_i  = (feedIdx < 2*n*n) && ($urandom_range(99) < 32'(inPct));
            in_data_i   = (feedIdx < n*n) ? aMat[feedIdx] :
                          (feedIdx < 2*n*n) ? bMat[feedIdx-n*n] : 32'hDEAD_BEEF;
            out_ready_i = (readyMode == 0) ? 1'b1 :
                          (readyMode == 1) ? cyc[0] : 1'($urandom_range(1));
            #1;
            if (mult_enable_o) enCnt++;
            if (in_valid_i && in_ready_o) begin
                if (feedIdx == 2*n*n-1) lastBCyc = cyc;
                feedIdx++;
            end
            if (out_valid_o) begin
                if (firstValidCyc < 0) firstValidCyc = cyc;
                if (stalled) begin
                    checkOutput("stall_data", {32'd0, out_data_o}, {32'd0, prevData});
                    checkOutput("stall_last", {63'd0, out_last_o}, {63'd0, prevLast});
                end
                checkOutput("out_data", {32'd0, out_data_o}, {32'd0, expC[outIdx]});
                checkOutput("out_last", {63'd0, out_last_o}, {63'd0, outIdx == n*n-1});
                if (out_ready_i) begin
                    outIdx++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    prevData = out_data_o;
                    prevLast = out_last_o;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        if (outIdx < n*n) checkOutput("job_timeout", 64'(outIdx), 64'(n*n));
        checkOutput("enable_cycles", 64'(enCnt), 64'd2);
        checkOutput("first_valid_latency", 64'(firstValidCyc - lastBCyc), 64'd4);
        checkOutput("busy_after_last", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic sizeErrCase(input logic [31:0] n);
        int errCnt;
        logic anyReady, anyBusy;
        errCnt = 0; anyReady = 1'b0; anyBusy = 1'b0;
        @(negedge clk);
        start_i       = 1'b1;
        matrix_size_i = n;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (size_err_o) errCnt++;
            anyReady |= in_ready_o;
            anyBusy  |= busy_o;
            @(negedge clk);
        end
        checkOutput("size_err_pulses", 64'(errCnt), 64'd1);
        checkOutput("size_err_in_ready", {63'd0, anyReady}, 64'd0);
        checkOutput("size_err_busy", {63'd0, anyBusy}, 64'd0);
    endtask

    initial begin
        int n;
        int hs;
        rst = 1'b1; start_i = 1'b0; matrix_size_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        #12;
        checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset_mult_A", {63'd0, |mult_A_o}, 64'd0);
        checkOutput("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] n=2 directed job");
        for (int i = 0; i < 4; i++) begin aMat[i] = 32'(i + 1); bMat[i] = 32'(i + 5); end
        applyStimulus(2, 100, 0);

        $display("[TB] n=1 directed job");
        aMat[0] = 32'd7; bMat[0] = 32'd6;
        applyStimulus(1, 100, 0);

        $display("[TB] invalid sizes");
        sizeErrCase(32'd0);
        sizeErrCase(32'd11);

        $display("[TB] n=3 with input gaps and output stalls");
        for (int i = 0; i < 9; i++) begin aMat[i] = $urandom; bMat[i] = $urandom; end
        applyStimulus(3, 50, 1);

        $display("[TB] reset during LOAD_B");
        @(negedge clk);
        start_i = 1'b1; matrix_size_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        hs = 0;
        for (int c = 0; c < 100 && hs < 21; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = $urandom | 32'h1;
            #1;
            if (in_ready_o) hs++;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("midreset_in_ready", {63'd0, in_ready_o}, 64'd0);
        checkOutput("midreset_mult_size", {32'd0, mult_size_o}, 64'd0);
        checkOutput("midreset_mult_AB", {63'd0, |{mult_A_o, mult_B_o}}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin aMat[i] = $urandom; bMat[i] = $urandom; end
        applyStimulus(2, 100, 0);
        checkOutput("outside_n_zero", {32'd0, mult_A_o[2*DW +: DW]}, 64'd0);

        $display("[TB] n=10 identity and wrap");
        for (int i = 0; i < 100; i++) begin
            aMat[i] = 32'(i);
            bMat[i] = (i / 10 == i % 10) ? 32'd1 : 32'd0;
        end
        applyStimulus(10, 100, 0);
        for (int i = 0; i < 100; i++) begin
            aMat[i] = $urandom;
            bMat[i] = (i / 10 == i % 10) ? 32'd2 : 32'd0;
        end
        aMat[37] = 32'hFFFF_FFFF;
        applyStimulus(10, 80, 2);

        $display("[TB] random jobs");
        for (int j = 0; j < 4; j++) begin
            n = int'($urandom_range(1, MAX));
            for (int i = 0; i < n*n; i++) begin aMat[i] = $urandom; bMat[i] = $urandom; end
            applyStimulus(n, 40 + 20*j, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
